axis_pkt_arbiter: RTL

AXIS_PKT_ARBITER -- requirements
Module: axis_pkt_arbiter

---
 rtl/axis_pkt_arbiter_pkg.sv | 17 +
 rtl/axis_pkt_arbiter_if.sv | 46 ++++
 rtl/axis_skid_buffer.sv | 48 ++++
 rtl/axis_pkt_arbiter.sv | 129 ++++++++++++
 4 files changed

// File: rtl/axis_pkt_arbiter_pkg.sv
// Shared types and constants for the AXI-Stream packet arbiter.
package axis_pkt_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PASS = 1'b1
  } arb_state_e;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  // Source index width; a single source still gets a 1-bit index.
  function automatic int tid_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_pkt_arbiter_if.sv
// Bundle of the N slave streams and the single master stream around the arbiter.
// AXIS_PKT_ARBITER_TID_EN adds m_tid (source index of each beat).
interface axis_pkt_arbiter_if
  import axis_pkt_arbiter_pkg::*;
#(
  parameter int NUM_SOURCES = 2,
  parameter int DATA_WIDTH  = 32,
  parameter int USER_WIDTH  = 8
);
  localparam int TID_W = tid_w(NUM_SOURCES);

  logic [NUM_SOURCES-1:0]            s_tvalid;
  logic [NUM_SOURCES-1:0]            s_tready;
  logic [NUM_SOURCES-1:0]            s_tlast;
  logic [USER_WIDTH*NUM_SOURCES-1:0] s_tuser;
  logic [DATA_WIDTH*NUM_SOURCES-1:0] s_tdata;

  logic                  m_tvalid;
  logic                  m_tready;
  logic                  m_tlast;
  logic [USER_WIDTH-1:0] m_tuser;
  logic [DATA_WIDTH-1:0] m_tdata;

`ifdef AXIS_PKT_ARBITER_TID_EN
  logic [TID_W-1:0]      m_tid;

  modport slave (
    input  s_tvalid, s_tlast, s_tuser, s_tdata, m_tready,
    output s_tready, m_tvalid, m_tlast, m_tuser, m_tdata, m_tid
  );
  modport master (
    output s_tvalid, s_tlast, s_tuser, s_tdata, m_tready,
    input  s_tready, m_tvalid, m_tlast, m_tuser, m_tdata, m_tid
  );
`else
  modport slave (
    input  s_tvalid, s_tlast, s_tuser, s_tdata, m_tready,
    output s_tready, m_tvalid, m_tlast, m_tuser, m_tdata
  );
  modport master (
    output s_tvalid, s_tlast, s_tuser, s_tdata, m_tready,
    input  s_tready, m_tvalid, m_tlast, m_tuser, m_tdata
  );
`endif

endinterface

// File: rtl/axis_skid_buffer.sv
// Two-entry valid/ready register slice: output register plus one skid entry.
// Upstream ready is registered (low only while the skid entry holds data).
module axis_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data
);

  logic             r_out_vld, r_skid_vld;
  logic [WIDTH-1:0] r_out_dat, r_skid_dat;
  logic             w_in_fire, w_out_free;

  assign o_ready    = ~r_skid_vld;
  assign w_in_fire  = i_valid & ~r_skid_vld;
  assign w_out_free = ~r_out_vld | i_ready;
  assign o_valid    = r_out_vld;
  assign o_data     = r_out_dat;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_out_vld  <= 1'b0;
      r_skid_vld <= 1'b0;
      r_out_dat  <= '0;
      r_skid_dat <= '0;
    end else if (w_out_free) begin
      // Skid entry drains first so ordering is preserved.
      if (r_skid_vld) begin
        r_out_vld  <= 1'b1;
        r_out_dat  <= r_skid_dat;
        r_skid_vld <= 1'b0;
      end else begin
        r_out_vld <= w_in_fire;
        if (w_in_fire) r_out_dat <= i_data;
      end
    end else if (w_in_fire) begin
      r_skid_vld <= 1'b1;
      r_skid_dat <= i_data;
    end
  end

endmodule

// File: rtl/axis_pkt_arbiter.sv
// Packet-granular N:1 AXI-Stream arbiter (round-robin or fixed priority).
// AXIS_PKT_ARBITER_TID_EN carries the source index alongside each beat as m_tid.
module axis_pkt_arbiter
  import axis_pkt_arbiter_pkg::*;
#(
  parameter int NUM_SOURCES = 2,
  parameter int DATA_WIDTH  = 32,
  parameter int USER_WIDTH  = 8,
  parameter int ARB_MODE    = ARB_RR
) (
  input  logic                   clk,
  input  logic                   arst,
  axis_pkt_arbiter_if.slave      axis,
  output logic [NUM_SOURCES-1:0] grant
);

  localparam int IDX_W = tid_w(NUM_SOURCES);
`ifdef AXIS_PKT_ARBITER_TID_EN
  localparam int SW = DATA_WIDTH + USER_WIDTH + 1 + IDX_W;
`else
  localparam int SW = DATA_WIDTH + USER_WIDTH + 1;
`endif

  arb_state_e             r_state, w_state_nxt;
  logic [NUM_SOURCES-1:0] r_grant, w_grant_nxt, w_s_tready;
  logic [IDX_W-1:0]       r_gidx, w_gidx_nxt, r_last, w_last_nxt, w_pick;
  logic                   w_src_vld, w_src_lst, w_slice_rdy, w_fire;
  logic [DATA_WIDTH-1:0]  w_src_dat;
  logic [USER_WIDTH-1:0]  w_src_usr;
  logic [SW-1:0]          w_slice_in, w_slice_out;

  // Reverse scan so the candidate closest to the search start wins.
  always_comb begin
    int c;
    c      = 0;
    w_pick = '0;
    if (ARB_MODE == ARB_FIXED) begin
      for (int i = NUM_SOURCES - 1; i >= 0; i--)
        if (axis.s_tvalid[i]) w_pick = IDX_W'(i);
    end else begin
      for (int k = NUM_SOURCES; k >= 1; k--) begin
        c = int'(r_last) + k;
        if (c >= NUM_SOURCES) c = c - NUM_SOURCES;
        if (axis.s_tvalid[c]) w_pick = IDX_W'(c);
      end
    end
  end

  always_comb begin
    w_src_vld = 1'b0;
    w_src_lst = 1'b0;
    w_src_dat = '0;
    w_src_usr = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (r_grant[i]) begin
        w_src_vld = axis.s_tvalid[i];
        w_src_lst = axis.s_tlast[i];
        w_src_dat = axis.s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        w_src_usr = axis.s_tuser[i*USER_WIDTH +: USER_WIDTH];
      end
    end
  end

  // r_grant is zero outside PASS, so w_fire can only occur while passing.
  assign w_fire = w_src_vld & w_slice_rdy;

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_gidx_nxt  = r_gidx;
    w_last_nxt  = r_last;
    w_s_tready  = '0;
    case (r_state)
      IDLE: begin
        if (|axis.s_tvalid) begin
          w_state_nxt = PASS;
          w_grant_nxt = NUM_SOURCES'(1) << w_pick;
          w_gidx_nxt  = w_pick;
        end
      end
      PASS: begin
        w_s_tready = r_grant & {NUM_SOURCES{w_slice_rdy}};
        if (w_fire && w_src_lst) begin
          w_state_nxt = IDLE;
          w_grant_nxt = '0;
          if (ARB_MODE == ARB_RR) w_last_nxt = r_gidx;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_gidx  <= '0;
      r_last  <= IDX_W'(NUM_SOURCES - 1);
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_gidx  <= w_gidx_nxt;
      r_last  <= w_last_nxt;
    end
  end

  assign axis.s_tready = w_s_tready;
  assign grant         = r_grant;

`ifdef AXIS_PKT_ARBITER_TID_EN
  assign w_slice_in = {r_gidx, w_src_lst, w_src_usr, w_src_dat};
  assign {axis.m_tid, axis.m_tlast, axis.m_tuser, axis.m_tdata} = w_slice_out;
`else
  assign w_slice_in = {w_src_lst, w_src_usr, w_src_dat};
  assign {axis.m_tlast, axis.m_tuser, axis.m_tdata} = w_slice_out;
`endif

  axis_skid_buffer #(.WIDTH(SW)) u_slice (
    .clk     (clk),
    .arst    (arst),
    .i_valid (w_src_vld),
    .o_ready (w_slice_rdy),
    .i_data  (w_slice_in),
    .o_valid (axis.m_tvalid),
    .i_ready (axis.m_tready),
    .o_data  (w_slice_out)
  );

endmodule
